// File: rtl/ipml_fifo_pkg.sv
// Shared constants and helpers for the ipml FIFO controller family.
// Read-mode selectors plus width helpers used by the controller and its interface.
package ipml_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Occupancy can reach D+2 in FWFT mode (RAM plus two pipeline words).
    function automatic int LVL_W(input int dw);
        return dw + 2;
    endfunction

endpackage

// File: rtl/ipml_sfifo_ctrl_v2_if.sv
// Control/status bundle between a FIFO controller and its user.
// Slave modport is the controller side, master modport the user side.
interface ipml_sfifo_ctrl_v2_if #(
    parameter int DW = 9
);
    import ipml_fifo_pkg::*;

    localparam int LW = LVL_W(DW);

    logic          w_en;
    logic [DW-1:0] waddr;
    logic          ram_we;
    logic          wfull;
    logic          almost_full;
    logic          r_en;
    logic [DW-1:0] raddr;
    logic          ram_re;
    logic          dout_load;
    logic          rempty;
    logic          almost_empty;
    logic [LW-1:0] water_level;
    logic          thr_we;
    logic [LW-1:0] af_thresh_in;
    logic [LW-1:0] ae_thresh_in;
    logic          overflow;
    logic          underflow;
    logic          clr_err;

    modport slave (
        input  w_en, r_en, thr_we, af_thresh_in, ae_thresh_in, clr_err,
        output waddr, ram_we, wfull, almost_full, raddr, ram_re, dout_load,
               rempty, almost_empty, water_level, overflow, underflow
    );

    modport master (
        output w_en, r_en, thr_we, af_thresh_in, ae_thresh_in, clr_err,
        input  waddr, ram_we, wfull, almost_full, raddr, ram_re, dout_load,
               rempty, almost_empty, water_level, overflow, underflow
    );

endinterface

// File: rtl/ipml_fifo_fwft_stage.sv
// Two-word prefetch pipeline (RAM output + output register) for first-word-fall-through.
// Keeps the RAM output and the output register full so one word can be consumed every cycle.
module ipml_fifo_fwft_stage (
    input  logic clk,
    input  logic rst,
    input  logic mem_nz_i,
    input  logic r_en_i,
    output logic ram_re_o,
    output logic load_o,
    output logic out_valid_o,
    output logic ram_valid_d_o,
    output logic out_valid_d_o
);

    logic ram_valid_q, out_valid_q;
    logic ram_valid_d, out_valid_d;
    logic consume, load, ram_re;

    assign consume     = r_en_i & out_valid_q;
    assign load        = ram_valid_q & (~out_valid_q | consume);
    assign ram_re      = mem_nz_i & (~ram_valid_q | load);
    assign ram_valid_d = ram_re | (ram_valid_q & ~load);
    assign out_valid_d = load | (out_valid_q & ~consume);

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            ram_valid_q <= ram_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ram_re_o      = ram_re;
    assign load_o        = load;
    assign out_valid_o   = out_valid_q;
    assign ram_valid_d_o = ram_valid_d;
    assign out_valid_d_o = out_valid_d;

endmodule

// File: rtl/ipml_sfifo_ctrl_v2.sv
// Single-clock FIFO controller for an external 1-cycle-latency simple-dual-port RAM.
// Standard or FWFT read mode; exact registered flags, programmable almost thresholds, sticky errors.
module ipml_sfifo_ctrl_v2
    import ipml_fifo_pkg::*;
#(
    parameter int c_DEPTH_WIDTH = 9,
    parameter int c_FWFT        = FIFO_MODE_STD,
    parameter int c_AF_RESET    = 508,
    parameter int c_AE_RESET    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    ipml_sfifo_ctrl_v2_if.slave    bus
);

    localparam int DW = c_DEPTH_WIDTH;
    localparam int LW = LVL_W(DW);
    localparam int CW = DW + 1;
    localparam logic [CW-1:0] DEPTH = {1'b1, {DW{1'b0}}};

    logic [DW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] mem_cnt_q, mem_cnt_d;
    logic [LW-1:0] lvl_q, lvl_d, af_q, ae_q;
    logic          wfull_q, ovf_q, unf_q;
    logic          wr_ok, ram_re, rempty, unf_evt, dout_load;

    assign wr_ok     = bus.w_en & ~wfull_q;
    assign mem_cnt_d = mem_cnt_q + CW'(wr_ok) - CW'(ram_re);

    generate
        if (c_FWFT == FIFO_MODE_FWFT) begin : g_fwft
            logic out_valid, ram_valid_d, out_valid_d, load;

            ipml_fifo_fwft_stage u_stage (
                .clk           (clk),
                .rst           (rst),
                .mem_nz_i      (mem_cnt_q != '0),
                .r_en_i        (bus.r_en),
                .ram_re_o      (ram_re),
                .load_o        (load),
                .out_valid_o   (out_valid),
                .ram_valid_d_o (ram_valid_d),
                .out_valid_d_o (out_valid_d)
            );

            assign rempty    = ~out_valid;
            assign unf_evt   = bus.r_en & ~out_valid;
            assign dout_load = load;
            // Words sitting in the prefetch pipeline still count as occupancy.
            assign lvl_d     = LW'(mem_cnt_d) + LW'(ram_valid_d) + LW'(out_valid_d);
        end else begin : g_std
            logic rempty_q;

            always_ff @(posedge clk) begin
                if (rst) rempty_q <= 1'b1;
                else     rempty_q <= (mem_cnt_d == '0);
            end

            assign ram_re    = bus.r_en & ~rempty_q;
            assign rempty    = rempty_q;
            assign unf_evt   = bus.r_en & rempty_q;
            assign dout_load = 1'b0;
            assign lvl_d     = LW'(mem_cnt_d);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            mem_cnt_q <= '0;
            wfull_q   <= 1'b0;
            lvl_q     <= '0;
            af_q      <= LW'(c_AF_RESET);
            ae_q      <= LW'(c_AE_RESET);
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            if (wr_ok)  wptr_q <= wptr_q + 1'b1;
            if (ram_re) rptr_q <= rptr_q + 1'b1;
            mem_cnt_q <= mem_cnt_d;
            wfull_q   <= (mem_cnt_d == DEPTH);
            lvl_q     <= lvl_d;
            if (bus.thr_we) begin
                af_q <= bus.af_thresh_in;
                ae_q <= bus.ae_thresh_in;
            end
            // A new error event wins over a simultaneous clear.
            ovf_q <= (bus.w_en & wfull_q) | (ovf_q & ~bus.clr_err);
            unf_q <= unf_evt | (unf_q & ~bus.clr_err);
        end
    end

    assign bus.waddr        = wptr_q;
    assign bus.raddr        = rptr_q;
    assign bus.ram_we       = wr_ok;
    assign bus.ram_re       = ram_re;
    assign bus.dout_load    = dout_load;
    assign bus.wfull        = wfull_q;
    assign bus.rempty       = rempty;
    assign bus.water_level  = lvl_q;
    assign bus.almost_full  = (lvl_q >= af_q);
    assign bus.almost_empty = (lvl_q <= ae_q);
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_ipml_sfifo_ctrl_v2.sv
// Directed bench: one standard-mode and one FWFT-mode controller, both depth 16.
module tb_ipml_sfifo_ctrl_v2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ipml_sfifo_ctrl_v2_if #(.DW(4)) bs ();
    ipml_sfifo_ctrl_v2_if #(.DW(4)) bf ();

    ipml_sfifo_ctrl_v2 #(
        .c_DEPTH_WIDTH(4), .c_FWFT(0), .c_AF_RESET(14), .c_AE_RESET(2)
    ) u_std (
        .clk(clk), .rst(rst), .bus(bs)
    );

    ipml_sfifo_ctrl_v2 #(
        .c_DEPTH_WIDTH(4), .c_FWFT(1), .c_AF_RESET(14), .c_AE_RESET(2)
    ) u_fw (
        .clk(clk), .rst(rst), .bus(bf)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bs.w_en = 0; bs.r_en = 0; bs.thr_we = 0; bs.clr_err = 0;
        bs.af_thresh_in = '0; bs.ae_thresh_in = '0;
        bf.w_en = 0; bf.r_en = 0; bf.thr_we = 0; bf.clr_err = 0;
        bf.af_thresh_in = '0; bf.ae_thresh_in = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
    endtask

    initial begin
        idle_all();
        do_reset();

        // Reset state
        chk("rst_std_rempty", bs.rempty, 1);
        chk("rst_std_wfull", bs.wfull, 0);
        chk("rst_std_level", bs.water_level, 0);
        chk("rst_std_ovf", bs.overflow, 0);
        chk("rst_std_ae", bs.almost_empty, 1);
        chk("rst_fw_rempty", bf.rempty, 1);
        chk("rst_fw_dload", bf.dout_load, 0);

        // Fill to full, then a refused 17th write
        for (int i = 0; i < 16; i++) begin
            bs.w_en = 1;
            #1;
            chk("fill_we", bs.ram_we, 1);
            chk("fill_waddr", bs.waddr, i);
            tick();
        end
        chk("full_wfull", bs.wfull, 1);
        chk("full_level", bs.water_level, 16);
        chk("full_af", bs.almost_full, 1);
        chk("full_we_refused", bs.ram_we, 0);
        tick();
        bs.w_en = 0;
        #1;
        chk("ovf_set", bs.overflow, 1);
        chk("ovf_level", bs.water_level, 16);
        bs.clr_err = 1;
        tick();
        bs.clr_err = 0;
        #1;
        chk("ovf_clr", bs.overflow, 0);

        // Simultaneous write and read while full
        bs.w_en = 1; bs.r_en = 1;
        #1;
        chk("full_rw_we", bs.ram_we, 0);
        chk("full_rw_re", bs.ram_re, 1);
        tick();
        bs.w_en = 0; bs.r_en = 0;
        #1;
        chk("full_rw_level", bs.water_level, 15);
        chk("full_rw_wfull", bs.wfull, 0);
        chk("full_rw_ovf", bs.overflow, 1);

        // Underflow from reset, then a single write/read
        do_reset();
        bs.r_en = 1;
        #1;
        chk("empty_re", bs.ram_re, 0);
        tick();
        bs.r_en = 0;
        #1;
        chk("unf_set", bs.underflow, 1);
        chk("unf_rempty", bs.rempty, 1);
        bs.clr_err = 1;
        tick();
        bs.clr_err = 0;
        bs.w_en = 1;
        tick();
        bs.w_en = 0;
        #1;
        chk("one_rempty", bs.rempty, 0);
        chk("one_unf_clr", bs.underflow, 0);
        bs.r_en = 1;
        #1;
        chk("one_re", bs.ram_re, 1);
        chk("one_raddr", bs.raddr, 0);
        tick();
        bs.r_en = 0;
        #1;
        chk("one_rempty_after", bs.rempty, 1);
        chk("one_level_after", bs.water_level, 0);

        // Pointer wrap with steady write/read pairs
        do_reset();
        bs.w_en = 1;
        tick();
        bs.r_en = 1;
        for (int i = 0; i < 40; i++) begin
            #1;
            chk("wrap_we", bs.ram_we, 1);
            chk("wrap_re", bs.ram_re, 1);
            chk("wrap_waddr", bs.waddr, (i + 1) % 16);
            chk("wrap_raddr", bs.raddr, i % 16);
            chk("wrap_level", bs.water_level, 1);
            tick();
        end
        bs.w_en = 0; bs.r_en = 0;
        #1;
        chk("wrap_ovf", bs.overflow, 0);
        chk("wrap_unf", bs.underflow, 0);

        // FWFT single-word latency
        do_reset();
        bf.w_en = 1;
        tick();
        bf.w_en = 0;
        #1;
        chk("fw_t1_re", bf.ram_re, 1);
        chk("fw_t1_dload", bf.dout_load, 0);
        chk("fw_t1_rempty", bf.rempty, 1);
        tick();
        chk("fw_t2_re", bf.ram_re, 0);
        chk("fw_t2_dload", bf.dout_load, 1);
        chk("fw_t2_rempty", bf.rempty, 1);
        chk("fw_t2_level", bf.water_level, 1);
        tick();
        chk("fw_t3_rempty", bf.rempty, 0);
        chk("fw_t3_level", bf.water_level, 1);
        chk("fw_t3_dload", bf.dout_load, 0);

        // FWFT back-to-back consumption
        bf.w_en = 1;
        repeat (10) tick();
        bf.w_en = 0;
        tick();
        chk("fw_burst_level", bf.water_level, 11);
        bf.r_en = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("fw_burst_dload", bf.dout_load, 1);
            chk("fw_burst_rempty", bf.rempty, 0);
            tick();
        end
        #1;
        chk("fw_burst_tail_dload", bf.dout_load, 0);
        chk("fw_burst_tail_level", bf.water_level, 1);
        tick();
        chk("fw_drained_rempty", bf.rempty, 1);
        chk("fw_drained_level", bf.water_level, 0);
        chk("fw_drained_unf", bf.underflow, 0);
        tick();
        bf.r_en = 0;
        #1;
        chk("fw_unf_set", bf.underflow, 1);

        // Programmable thresholds
        do_reset();
        bs.thr_we = 1; bs.af_thresh_in = 6'd3; bs.ae_thresh_in = 6'd1;
        tick();
        bs.thr_we = 0;
        bs.w_en = 1;
        tick();
        chk("thr_l1_ae", bs.almost_empty, 1);
        chk("thr_l1_af", bs.almost_full, 0);
        tick();
        chk("thr_l2_ae", bs.almost_empty, 0);
        chk("thr_l2_af", bs.almost_full, 0);
        tick();
        bs.w_en = 0;
        #1;
        chk("thr_l3_af", bs.almost_full, 1);
        bs.r_en = 1;
        tick();
        chk("thr_d2_af", bs.almost_full, 0);
        chk("thr_d2_ae", bs.almost_empty, 0);
        tick();
        bs.r_en = 0;
        #1;
        chk("thr_d1_ae", bs.almost_empty, 1);
        chk("thr_d1_level", bs.water_level, 1);

        // Reset in the middle of an FWFT burst
        do_reset();
        bf.thr_we = 1; bf.af_thresh_in = 6'd1; bf.ae_thresh_in = 6'd0;
        tick();
        bf.thr_we = 0;
        bf.w_en = 1;
        repeat (7) tick();
        bf.w_en = 0;
        tick();
        tick();
        chk("mid_level", bf.water_level, 7);
        chk("mid_af_prog", bf.almost_full, 1);
        bf.w_en = 1; bf.r_en = 1; rst = 1;
        tick();
        rst = 0; bf.w_en = 0; bf.r_en = 0;
        #1;
        chk("mid_rst_level", bf.water_level, 0);
        chk("mid_rst_rempty", bf.rempty, 1);
        chk("mid_rst_wfull", bf.wfull, 0);
        chk("mid_rst_dload", bf.dout_load, 0);
        chk("mid_rst_re", bf.ram_re, 0);
        tick();
        chk("mid_rst_dload2", bf.dout_load, 0);
        tick();
        chk("mid_rst_dload3", bf.dout_load, 0);
        bf.w_en = 1;
        tick();
        tick();
        bf.w_en = 0;
        #1;
        chk("mid_rst_l2", bf.water_level, 2);
        chk("mid_rst_ae_thr", bf.almost_empty, 1);
        chk("mid_rst_af_thr", bf.almost_full, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ipml_sfifo_ctrl_v2.md
Name: ipml_sfifo_ctrl_v2

Overview:
Single-clock FIFO controller, next generation of the ipml FIFO controller family.
- Drives an external simple-dual-port RAM with 1-cycle registered read latency. The RAM holds its output when not read-enabled.
- Adds a selectable first-word-fall-through (FWFT) mode with a full-throughput prefetch pipeline.
- Adds runtime-programmable almost thresholds, sticky overflow/underflow error flags and exact (non-pessimistic) flags.

Parameters:
- c_DEPTH_WIDTH, 9, RAM address width (4..20); RAM depth D = 2^c_DEPTH_WIDTH.
- c_FWFT, 0, 0 = standard read mode, 1 = first-word-fall-through.
- c_AF_RESET, 508, reset value of the internal almost-full threshold.
- c_AE_RESET, 4, reset value of the internal almost-empty threshold.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- w_en  in  1  write request.
- waddr  out  c_DEPTH_WIDTH  RAM write address.
- ram_we  out  1  RAM write strobe (accepted write).
- wfull  out  1  full flag.
- almost_full  out  1  water_level >= af_thresh.
- r_en  in  1  read request / consume.
- raddr  out  c_DEPTH_WIDTH  RAM read address.
- ram_re  out  1  RAM read strobe.
- dout_load  out  1  FWFT only: load output data register from RAM output; tied 0 when c_FWFT=0.
- rempty  out  1  empty flag.
- almost_empty  out  1  water_level <= ae_thresh.
- water_level  out  c_DEPTH_WIDTH+2  occupancy.
- thr_we  in  1  load thresholds.
- af_thresh_in  in  c_DEPTH_WIDTH+2  new almost-full threshold.
- ae_thresh_in  in  c_DEPTH_WIDTH+2  new almost-empty threshold.
- overflow  out  1  sticky: write refused while full.
- underflow  out  1  sticky: read refused while empty.
- clr_err  in  1  clear sticky error flags.

Interface (already decided): one clock, clk; reset rst is synchronous and active-high.

Behaviour:
Reset (rst=1 at a clk edge):
- Pointers, mem_cnt, ram_valid, out_valid, water_level, wfull, overflow and underflow all go to 0.
- rempty goes to 1.
- Thresholds load c_AF_RESET / c_AE_RESET.
- rst overrides every other input, including mid-transfer; any in-flight RAM read is discarded.

Pointers and count:
- wptr and rptr are binary, c_DEPTH_WIDTH bits, and wrap D-1 -> 0 naturally. waddr = wptr, raddr = rptr.
- mem_cnt (c_DEPTH_WIDTH+1 bits) = words stored in RAM and not yet read from it.

Write side:
- wr_ok = w_en & !wfull. ram_we = wr_ok, and wptr increments in the same cycle.
- wfull is registered: wfull = (mem_cnt_next == D).
- A write while full is refused even if a read is accepted in the same cycle; it sets overflow.

Standard mode (c_FWFT=0):
- rd_ok = r_en & !rempty. ram_re = rd_ok; rptr increments; data is valid on the RAM output one cycle later.
- rempty is registered: rempty = (mem_cnt_next == 0).
- A read while empty is refused even if a write lands in the same cycle; it sets underflow.
- water_level = mem_cnt.
- Write at edge t -> rempty falls at t+1.

FWFT mode (c_FWFT=1): two state bits, ram_valid (RAM output holds an unconsumed word) and out_valid.
- rempty = !out_valid. Consume = r_en & out_valid. r_en while !out_valid sets underflow.
- load = ram_valid & (!out_valid | consume).
- ram_re = (mem_cnt != 0) & (!ram_valid | load).
- ram_valid_next = ram_re | (ram_valid & !load).
- out_valid_next = load | (out_valid & !consume).
- dout_load = load.
- Sustains one read per cycle.
- Write to an empty FIFO at edge t -> ram_re in cycle t+1 -> rempty falls at t+3.
- water_level = mem_cnt + ram_valid + out_valid (maximum D+2).
- wfull still refers to the RAM only (mem_cnt == D).

Common to both modes:
- mem_cnt_next = mem_cnt + ram_we - ram_re. Simultaneous accepted read and write leaves mem_cnt unchanged.
- water_level is registered and updates in the same edge as the pointers.
- almost_full and almost_empty are combinational compares of the registered water_level against the threshold registers.
- thr_we loads both thresholds at the next edge; the flags reflect the new values in that same cycle.
- overflow and underflow hold until clr_err or rst. If clr_err coincides with a new error event, the flag stays set (set wins).

Decomposition:
- Shared package ipml_fifo_pkg holds:
  - read-mode constants FIFO_MODE_STD / FIFO_MODE_FWFT;
  - function clog2;
  - level-width helper LVL_W(dw) = dw+2.
- One sub-module, ipml_fifo_fwft_stage: the ram_valid/out_valid prefetch logic. It is instantiated only when c_FWFT=1.

Test Plan:
1. Standard mode, c_DEPTH_WIDTH=4: 16 writes from reset -> wfull=1 after the 16th edge, water_level=16. A 17th w_en -> no ram_we, overflow=1. clr_err -> overflow=0.
2. Standard mode: r_en from reset -> no ram_re, underflow=1, rempty stays 1. One write, then r_en -> ram_re, raddr=0, rempty=1 again after the read.
3. Wrap: 40 write/read pairs at depth 16 -> waddr/raddr wrap 15->0, mem_cnt never exceeds 1, no error flags. Simultaneous w_en&r_en at full -> write refused, read accepted, water_level drops 16->15.
4. FWFT: single write at edge t -> ram_re in cycle t+1, dout_load in cycle t+2, rempty=0 at t+3, water_level=1. Continuous r_en with 10 words queued -> 10 consecutive dout_load/consume cycles, no bubbles.
5. Thresholds: thr_we with af=3, ae=1; fill 3 -> almost_full=1 exactly at level 3; drain to 1 -> almost_empty=1.
6. rst asserted mid-burst (level 7, ram_valid=1) -> next edge: level 0, rempty=1, wfull=0, thresholds back to reset values, no dout_load afterwards.
